mem_access: RTL and testbench

- Memory-access (MA) stage logic. Sits between the EX/MA pipeline register and the MA/WB pipeline register.
- Non-memory ops: passes pc/rd/result straight through, combinationally.
- Loads/stores: runs a valid/ready request plus response handshake on the data bus.
- Loads: aligns and sign/zero-extends read data.
- Stores: builds byte masks.
- Raises stall_req to freeze the pipeline while a bus transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 9 +
 rtl/mem_align.sv | 25 ++
 rtl/mem_access.sv | 184 ++++++++++++++++++
 tb/tb_mem_access.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the MA stage (memory op, access size, FSM state).
package mem_access_pkg;
  typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_op_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} mem_size_e;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane shifting for stores (data + byte enables) and loads (shift + extend).
module mem_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] st_data,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  output logic [63:0] ldata
);
  logic [7:0]  base;
  logic [63:0] sh;
  always_comb begin
    base  = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
    wmask = base << lane;
    wdata = st_data << {lane, 3'b000};
    sh    = rdata >> {lane, 3'b000};
    ldata = size == SZ_B ? {{56{~uns & sh[7]}}, sh[7:0]} :
            size == SZ_H ? {{48{~uns & sh[15]}}, sh[15:0]} :
            size == SZ_W ? {{32{~uns & sh[31]}}, sh[31:0]} : sh;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: MA pipeline stage with valid/ready data-bus handshake, load/store alignment and stall control.
// Define MA_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int PC_W   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              trap_en,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   pc,
  input  logic [4:0]        rd,
  input  logic [63:0]       alu_res,
  input  logic [63:0]       st_data,
  input  logic [1:0]        mem_op,
  input  logic [1:0]        mem_size,
  input  logic              mem_uns,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [63:0]       req_wdata,
  output logic [7:0]        req_wmask,
  input  logic              rsp_valid,
  input  logic [63:0]       rsp_rdata,
  output logic              stall_req,
  output logic [PC_W-1:0]   pc_out,
  output logic [4:0]        rd_out,
  output logic [63:0]       data_out,
  output logic              misalign,
  output logic [63:0]       bad_addr
);
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic [7:0]        wmask;
    logic [2:0]        lane;
    logic [1:0]        size;
    logic              uns;
    logic [4:0]        rd;
    logic [PC_W-1:0]   pc;
  } req_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [63:0]     data;
  } wb_t;
  state_e      state_q, state_d;
  req_t        req_q, req_d, req_in;
  wb_t         hold_q, hold_d, ack_wb;
  logic        kill_q, kill_d;
  logic        is_mem, kill_in, mis, issue, idle;
  logic [63:0] eff;
  logic [2:0]  al_lane;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [63:0] al_wdata, al_ldata;
  logic [7:0]  al_wmask;
  assign is_mem  = in_valid && mem_op != MEM_NONE;
  assign kill_in = clear || trap_en;
  assign idle    = state_q == S_IDLE;
`ifdef MA_MISALIGN_TRAP_EN
  assign mis = idle && is_mem && !kill_in && (alu_res[2:0] & size_mask(mem_size)) != 3'b000;
  assign eff = alu_res;
`else
  assign mis = 1'b0;
  assign eff = alu_res & ~{61'b0, size_mask(mem_size)};
`endif
  assign issue = idle && is_mem && !kill_in && !mis;
  // One aligner: store lanes from live inputs while issuing, load lanes from the captured request afterwards.
  assign al_lane = idle ? eff[2:0] : req_q.lane;
  assign al_size = idle ? mem_size : req_q.size;
  assign al_uns  = idle ? mem_uns : req_q.uns;
  mem_align u_align (
    .lane    (al_lane),
    .size    (al_size),
    .uns     (al_uns),
    .st_data (st_data),
    .rdata   (rsp_rdata),
    .wdata   (al_wdata),
    .wmask   (al_wmask),
    .ldata   (al_ldata)
  );
  assign req_in = '{
    we:    mem_op == MEM_STORE,
    addr:  {eff[ADDR_W-1:3], 3'b000},
    wdata: al_wdata,
    wmask: al_wmask,
    lane:  eff[2:0],
    size:  mem_size,
    uns:   mem_uns,
    rd:    rd,
    pc:    pc
  };
  assign ack_wb = '{pc: req_q.pc, rd: req_q.we ? 5'd0 : req_q.rd, data: req_q.we ? 64'd0 : al_ldata};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      hold_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      kill_q  <= kill_d;
    end
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    hold_d  = hold_q;
    kill_d  = kill_q;
    case (state_q)
      S_IDLE: if (issue) begin
        req_d   = req_in;
        kill_d  = 1'b0;
        state_d = req_ready ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        // A killed request stays on the bus until accepted; its response is then drained.
        kill_d = kill_q || kill_in;
        if (req_ready) state_d = (kill_q || kill_in) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: if (rsp_valid) begin
        hold_d  = ack_wb;
        state_d = (kill_in || !stall) ? S_IDLE : S_HOLD;
      end else if (kill_in) begin
        state_d = S_DRAIN;
      end
      S_HOLD:  if (!stall) state_d = S_IDLE;
      S_DRAIN: if (rsp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req_valid = 1'b0;
    req_we    = req_q.we;
    req_addr  = req_q.addr;
    req_wdata = req_q.wdata;
    req_wmask = req_q.wmask;
    stall_req = 1'b0;
    pc_out    = pc;
    rd_out    = 5'd0;
    data_out  = 64'd0;
    misalign  = mis;
    bad_addr  = mis ? alu_res : 64'd0;
    case (state_q)
      S_IDLE: begin
        req_valid = issue;
        req_we    = req_in.we;
        req_addr  = req_in.addr;
        req_wdata = req_in.wdata;
        req_wmask = req_in.wmask;
        stall_req = issue;
        rd_out    = (in_valid && !is_mem && !kill_in) ? rd : 5'd0;
        data_out  = (in_valid && !is_mem) ? alu_res : 64'd0;
      end
      S_REQ: begin
        req_valid = 1'b1;
        stall_req = 1'b1;
        pc_out    = req_q.pc;
      end
      S_WAIT: begin
        stall_req = !rsp_valid;
        pc_out    = req_q.pc;
        rd_out    = (rsp_valid && !kill_in) ? ack_wb.rd : 5'd0;
        data_out  = (rsp_valid && !kill_in) ? ack_wb.data : 64'd0;
      end
      S_HOLD: begin
        pc_out   = hold_q.pc;
        rd_out   = hold_q.rd;
        data_out = hold_q.data;
      end
      S_DRAIN: stall_req = is_mem;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven, directed and randomized checks of mem_access against a byte-level reference model.
module tb_mem_access;
  localparam int PC_W = 64;
  localparam int ADDR_W = 64;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, trap_en = 1'b0, stall = 1'b0, in_valid = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic [4:0] rd = '0;
  logic [63:0] alu_res = '0, st_data = '0, rsp_rdata = '0;
  logic [1:0] mem_op = '0, mem_size = '0;
  logic mem_uns = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0;
  logic req_valid, req_we, stall_req, misalign;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0] req_wdata, data_out, bad_addr;
  logic [7:0] req_wmask;
  logic [PC_W-1:0] pc_out;
  logic [4:0] rd_out;
  int n_tests = 0, n_fail = 0;

  mem_access #(.PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .trap_en(trap_en), .stall(stall), .in_valid(in_valid),
    .pc(pc), .rd(rd), .alu_res(alu_res), .st_data(st_data), .mem_op(mem_op), .mem_size(mem_size),
    .mem_uns(mem_uns), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .stall_req(stall_req), .pc_out(pc_out), .rd_out(rd_out),
    .data_out(data_out), .misalign(misalign), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       nm;
    logic [1:0]  op, size;
    logic        uns;
    logic [63:0] addr, sd, rdata;
    int          rdy, rspd, stl;
    logic [63:0] e_addr, e_wdata, e_data;
    logic [7:0]  e_mask;
  } vec_t;
  vec_t vecs[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [1:0] op, size, input logic uns,
                     input logic [63:0] addr, sd, rdata, input int rdy, rspd, stl,
                     input logic [63:0] e_addr, e_wdata, e_data, input logic [7:0] e_mask);
    vec_t v;
    v = '{nm, op, size, uns, addr, sd, rdata, rdy, rspd, stl, e_addr, e_wdata, e_data, e_mask};
    vecs.push_back(v);
  endtask

  // Reference: naturally align, then move whole bytes between lanes and extend by hand.
  task automatic model(input logic [1:0] op, size, input logic uns, input logic [63:0] addr, sd, rdata,
                       output logic [63:0] e_addr, e_wdata, e_data, output logic [7:0] e_mask);
    int nb, ln;
    logic [63:0] ea, v;
    nb = 1 << size;
    ea = addr - (addr % 64'(nb));
    ln = int'(ea % 64'd8);
    e_addr = ea - 64'(ln);
    e_mask = '0;
    for (int i = 0; i < nb; i++) e_mask[ln+i] = 1'b1;
    e_wdata = '0;
    for (int i = 0; i < 8 - ln; i++) e_wdata[8*(ln+i)+:8] = sd[8*i+:8];
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i+:8] = rdata[8*(ln+i)+:8];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i+:8] = 8'hFF;
    e_data = (op == 2'd2) ? 64'd0 : v;
  endtask

  task automatic do_mem(input string nm, input logic [1:0] op, size, input logic uns,
                        input logic [63:0] addr, sd, rdata, pcv, input logic [4:0] rdv,
                        input int rdy, rspd, stl,
                        input logic [63:0] e_addr, e_wdata, e_data, input logic [7:0] e_mask);
    logic [4:0] e_rd;
    e_rd = (op == 2'd2) ? 5'd0 : rdv;
    tick;
    in_valid = 1'b1; mem_op = op; mem_size = size; mem_uns = uns; alu_res = addr;
    st_data = sd; pc = pcv; rd = rdv; req_ready = (rdy == 0);
    samp;
    chk({nm, " req_valid"}, 64'(req_valid), 64'd1);
    chk({nm, " req_we"}, 64'(req_we), 64'(op == 2'd2));
    chk({nm, " req_addr"}, req_addr, e_addr);
    chk({nm, " req_wmask"}, 64'(req_wmask), 64'(e_mask));
    if (op == 2'd2) chk({nm, " req_wdata"}, req_wdata, e_wdata);
    chk({nm, " stall_req issue"}, 64'(stall_req), 64'd1);
    chk({nm, " rd_out issue"}, 64'(rd_out), 64'd0);
    chk({nm, " misalign"}, 64'(misalign), 64'd0);
    for (int i = 1; i <= rdy; i++) begin
      tick;
      req_ready = (i == rdy);
      samp;
      chk({nm, " req_valid held"}, 64'(req_valid), 64'd1);
      chk({nm, " req_addr held"}, req_addr, e_addr);
      if (op == 2'd2) chk({nm, " req_wdata held"}, req_wdata, e_wdata);
      chk({nm, " stall_req req"}, 64'(stall_req), 64'd1);
    end
    tick;
    req_ready = 1'b0;
    for (int i = 0; i < rspd; i++) begin
      samp;
      chk({nm, " stall_req wait"}, 64'(stall_req), 64'd1);
      chk({nm, " req_valid wait"}, 64'(req_valid), 64'd0);
      chk({nm, " rd_out wait"}, 64'(rd_out), 64'd0);
      tick;
    end
    rsp_valid = 1'b1; rsp_rdata = rdata; stall = (stl > 0);
    samp;
    chk({nm, " stall_req ack"}, 64'(stall_req), 64'd0);
    chk({nm, " rd_out ack"}, 64'(rd_out), 64'(e_rd));
    chk({nm, " data_out ack"}, data_out, e_data);
    chk({nm, " pc_out ack"}, pc_out, pcv);
    tick;
    rsp_valid = 1'b0; rsp_rdata = {$urandom, $urandom};
    for (int k = 1; k <= stl; k++) begin
      stall = (k < stl);
      samp;
      chk({nm, " stall_req hold"}, 64'(stall_req), 64'd0);
      chk({nm, " rd_out hold"}, 64'(rd_out), 64'(e_rd));
      chk({nm, " data_out hold"}, data_out, e_data);
      chk({nm, " pc_out hold"}, pc_out, pcv);
      tick;
    end
    in_valid = 1'b0; mem_op = 2'd0; stall = 1'b0;
  endtask

  initial begin
    logic [1:0] op, sz;
    logic uns;
    logic [63:0] addr, sd, rdata, ea, ew, ed, pcv;
    logic [7:0] em;
    logic [4:0] rdv;

    // Reset state
    tick; tick;
    samp;
    chk("reset req_valid", 64'(req_valid), 64'd0);
    chk("reset stall_req", 64'(stall_req), 64'd0);
    chk("reset rd_out", 64'(rd_out), 64'd0);
    chk("reset data_out", data_out, 64'd0);
    chk("reset pc_out", pc_out, 64'd0);
    tick;
    rst = 1'b0;

    // ALU pass-through
    in_valid = 1'b1; mem_op = 2'd0; pc = 64'h8000_0000; rd = 5'd5; alu_res = 64'h1234;
    samp;
    chk("alu pc_out", pc_out, 64'h8000_0000);
    chk("alu rd_out", 64'(rd_out), 64'd5);
    chk("alu data_out", data_out, 64'h1234);
    chk("alu req_valid", 64'(req_valid), 64'd0);
    chk("alu stall_req", 64'(stall_req), 64'd0);
    tick;
    in_valid = 1'b0;

    // Directed vector table
    add("lb", 2'd1, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2, 0, 0,
        64'h1000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 8'h08);
    add("lbu", 2'd1, 2'd0, 1'b1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2, 1, 0,
        64'h1000, 64'h0, 64'h80, 8'h08);
    add("sh", 2'd2, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0,
        64'h2000, 64'hBEEF_0000_0000_0000, 64'h0, 8'hC0);
    add("lw hold", 2'd1, 2'd2, 1'b0, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 0, 1, 2,
        64'h2000, 64'h0, 64'hFFFF_FFFF_8765_4321, 8'hF0);
    add("lh", 2'd1, 2'd1, 1'b0, 64'h12, 64'h0, 64'h0000_0000_8001_0000, 0, 0, 0,
        64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 8'h0C);
    add("sw", 2'd2, 2'd2, 1'b0, 64'h40C, 64'h1122_3344, 64'h0, 0, 2, 1,
        64'h408, 64'h1122_3344_0000_0000, 64'h0, 8'hF0);
    add("sd", 2'd2, 2'd3, 1'b0, 64'h500, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1, 1, 0,
        64'h500, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 8'hFF);
    add("lwu", 2'd1, 2'd2, 1'b1, 64'h8, 64'h0, 64'hFFFF_FFFF_8000_0000, 0, 0, 0,
        64'h8, 64'h0, 64'h8000_0000, 8'h0F);
    add("sb", 2'd2, 2'd0, 1'b0, 64'h7, 64'h1234_5678_9ABC_DEAB, 64'h0, 0, 0, 0,
        64'h0, 64'hAB00_0000_0000_0000, 64'h0, 8'h80);
`ifndef MA_MISALIGN_TRAP_EN
    add("ld misaligned", 2'd1, 2'd3, 1'b0, 64'h3004, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0,
        64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF);
`endif
    foreach (vecs[i])
      do_mem(vecs[i].nm, vecs[i].op, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].sd,
             vecs[i].rdata, 64'h8000_0000 + 64'(i * 4), 5'(i + 1), vecs[i].rdy, vecs[i].rspd,
             vecs[i].stl, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_data, vecs[i].e_mask);

`ifdef MA_MISALIGN_TRAP_EN
    tick;
    in_valid = 1'b1; mem_op = 2'd1; mem_size = 2'd3; alu_res = 64'h3004; rd = 5'd6;
    samp;
    chk("mis misalign", 64'(misalign), 64'd1);
    chk("mis bad_addr", bad_addr, 64'h3004);
    chk("mis req_valid", 64'(req_valid), 64'd0);
    chk("mis rd_out", 64'(rd_out), 64'd0);
    tick;
    in_valid = 1'b0; mem_op = 2'd0;
    samp;
    chk("mis pulse end", 64'(misalign), 64'd0);
    chk("mis idle req_valid", 64'(req_valid), 64'd0);
`endif

    // Clear in IDLE: op ignored
    tick;
    in_valid = 1'b1; mem_op = 2'd1; mem_size = 2'd2; alu_res = 64'h40; clear = 1'b1; rd = 5'd3;
    samp;
    chk("clear idle req_valid", 64'(req_valid), 64'd0);
    chk("clear idle stall_req", 64'(stall_req), 64'd0);
    tick;
    clear = 1'b0; in_valid = 1'b0; mem_op = 2'd0;
    samp;
    chk("clear idle no req", 64'(req_valid), 64'd0);

    // Trap in WAIT, response 3 cycles later, next load waits for drain
    tick;
    in_valid = 1'b1; mem_op = 2'd1; mem_size = 2'd2; mem_uns = 1'b0; alu_res = 64'h100;
    pc = 64'h400; rd = 5'd7; req_ready = 1'b1;
    samp;
    chk("trap issue", 64'(req_valid), 64'd1);
    tick;
    req_ready = 1'b0; trap_en = 1'b1;
    samp;
    chk("trap wait rd_out", 64'(rd_out), 64'd0);
    chk("trap wait req_valid", 64'(req_valid), 64'd0);
    tick;
    trap_en = 1'b0; alu_res = 64'h1003; mem_size = 2'd0; rd = 5'd9; pc = 64'h404;
    for (int i = 0; i < 2; i++) begin
      samp;
      chk("drain stall_req", 64'(stall_req), 64'd1);
      chk("drain req_valid", 64'(req_valid), 64'd0);
      chk("drain rd_out", 64'(rd_out), 64'd0);
      tick;
    end
    rsp_valid = 1'b1; rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    samp;
    chk("drain drop rd_out", 64'(rd_out), 64'd0);
    chk("drain drop req_valid", 64'(req_valid), 64'd0);
    tick;
    rsp_valid = 1'b0; req_ready = 1'b1;
    samp;
    chk("after drain req_valid", 64'(req_valid), 64'd1);
    chk("after drain req_addr", req_addr, 64'h1000);
    tick;
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 64'h0000_0000_8000_0000;
    samp;
    chk("after drain rd_out", 64'(rd_out), 64'd9);
    chk("after drain data_out", data_out, 64'hFFFF_FFFF_FFFF_FF80);
    tick;
    rsp_valid = 1'b0; in_valid = 1'b0; mem_op = 2'd0;

    // Clear in REQ: req_valid held until accepted, then drained
    tick;
    in_valid = 1'b1; mem_op = 2'd2; mem_size = 2'd3; alu_res = 64'h600; st_data = 64'h55;
    rd = 5'd2; req_ready = 1'b0;
    samp;
    chk("clrreq issue", 64'(req_valid), 64'd1);
    tick;
    clear = 1'b1;
    samp;
    chk("clrreq req_valid on clear", 64'(req_valid), 64'd1);
    chk("clrreq rd_out", 64'(rd_out), 64'd0);
    tick;
    clear = 1'b0; in_valid = 1'b0; mem_op = 2'd0;
    samp;
    chk("clrreq req_valid after", 64'(req_valid), 64'd1);
    chk("clrreq req_addr", req_addr, 64'h600);
    tick;
    req_ready = 1'b1;
    samp;
    chk("clrreq accept", 64'(req_valid), 64'd1);
    tick;
    req_ready = 1'b0;
    samp;
    chk("clrreq drain req_valid", 64'(req_valid), 64'd0);
    chk("clrreq drain stall_req", 64'(stall_req), 64'd0);
    tick;
    rsp_valid = 1'b1;
    samp;
    chk("clrreq drop rd_out", 64'(rd_out), 64'd0);
    tick;
    rsp_valid = 1'b0; in_valid = 1'b1; mem_op = 2'd0; alu_res = 64'h55; rd = 5'd3;
    samp;
    chk("clrreq idle rd_out", 64'(rd_out), 64'd3);
    chk("clrreq idle data_out", data_out, 64'h55);
    tick;
    in_valid = 1'b0;

    // Reset mid-WAIT
    tick;
    in_valid = 1'b1; mem_op = 2'd1; mem_size = 2'd2; alu_res = 64'h20; rd = 5'd4; pc = 64'h8;
    req_ready = 1'b1;
    samp;
    chk("rstw issue", 64'(req_valid), 64'd1);
    tick;
    req_ready = 1'b0;
    samp;
    chk("rstw wait stall", 64'(stall_req), 64'd1);
    tick;
    rst = 1'b1; in_valid = 1'b0; mem_op = 2'd0; alu_res = '0; rd = '0; pc = '0;
    tick;
    rst = 1'b0;
    samp;
    chk("rstw req_valid", 64'(req_valid), 64'd0);
    chk("rstw stall_req", 64'(stall_req), 64'd0);
    chk("rstw rd_out", 64'(rd_out), 64'd0);
    chk("rstw pc_out", pc_out, 64'd0);
    chk("rstw data_out", data_out, 64'd0);
    chk("rstw misalign", 64'(misalign), 64'd0);
    chk("rstw bad_addr", bad_addr, 64'd0);
    tick;
    rsp_valid = 1'b1; rsp_rdata = 64'h1;
    samp;
    chk("stray rsp rd_out", 64'(rd_out), 64'd0);
    chk("stray rsp stall_req", 64'(stall_req), 64'd0);
    tick;
    rsp_valid = 1'b0;

    // Randomized ops against the reference model
    for (int t = 0; t < 60; t++) begin
      op = 2'($urandom_range(0, 2));
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = {$urandom, $urandom};
      sd = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      pcv = {$urandom, $urandom};
      rdv = 5'($urandom_range(1, 31));
`ifdef MA_MISALIGN_TRAP_EN
      addr = addr - (addr % (64'd1 << sz));
`endif
      if (op == 2'd0) begin
        tick;
        in_valid = 1'b1; mem_op = 2'd0; alu_res = addr; pc = pcv; rd = rdv;
        samp;
        chk("rnd alu rd_out", 64'(rd_out), 64'(rdv));
        chk("rnd alu data_out", data_out, addr);
        chk("rnd alu pc_out", pc_out, pcv);
        chk("rnd alu req_valid", 64'(req_valid), 64'd0);
      end else begin
        model(op, sz, uns, addr, sd, rdata, ea, ew, ed, em);
        do_mem("rnd", op, sz, uns, addr, sd, rdata, pcv, rdv, $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2), ea, ew, ed, em);
      end
    end
    tick;
    in_valid = 1'b0;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
